// File: rtl/sprite_rle_if.sv
// Token stream and sprite RAM write port between the host/UART loader and
// sprite_rle_loader. The loader takes the slave modport.
interface sprite_rle_if #(
  parameter int X_BITS  = 6,
  parameter int Y_BITS  = 6,
  parameter int COLOR_W = 12,
  parameter int RUN_W   = 4
);
  logic                       in_valid;
  logic [RUN_W+COLOR_W-1:0]   in_data;
  logic                       in_ready;
  logic                       wr_en;
  logic [X_BITS+Y_BITS-1:0]   wr_addr;
  logic [COLOR_W-1:0]         wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sprite_rle_loader.sv
// Expands a run-length-encoded token stream into one sequential sprite RAM
// write per clock, row-major from address 0 up to the last pixel.
module sprite_rle_loader #(
  parameter int X_BITS  = 6,
  parameter int Y_BITS  = 6,
  parameter int COLOR_W = 12,
  parameter int RUN_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  sprite_rle_if.slave   bus,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int A_W   = X_BITS + Y_BITS;
  localparam int REM_W = RUN_W + 1;
  localparam logic [A_W-1:0] MAX_ADDR = '1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state, state_nxt;
  logic [A_W-1:0]       addr_p0, addr_nxt;
  logic [REM_W-1:0]     rem_p0, rem_nxt;
  logic [COLOR_W-1:0]   cur_color_p0, color_nxt;
  logic                 vld_p1, vld_nxt;
  logic [A_W-1:0]       wr_addr_p1, wr_addr_nxt;
  logic [COLOR_W-1:0]   wr_data_p1, wr_data_nxt;
  logic                 done_p1, done_nxt;
  logic                 ovf_q, ovf_nxt;
  logic                 in_ready_c;

  logic [RUN_W-1:0]     tok_run;
  logic [COLOR_W-1:0]   tok_color;

  assign tok_run   = bus.in_data[RUN_W+COLOR_W-1:COLOR_W];
  assign tok_color = bus.in_data[COLOR_W-1:0];

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_p0;
    rem_nxt     = rem_p0;
    color_nxt   = cur_color_p0;
    vld_nxt     = 1'b0;
    wr_addr_nxt = wr_addr_p1;
    wr_data_nxt = wr_data_p1;
    done_nxt    = 1'b0;
    ovf_nxt     = ovf_q;
    in_ready_c  = 1'b0;

    case (state)
      IDLE: begin
        // done_p1 high means the load just finished this cycle; that start is dropped
        if (start && !abort && !done_p1) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
          rem_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      LOAD: begin
        // Accept while the last pixel of the current run issues, unless that pixel is MAX
        in_ready_c = !abort &&
                     ((rem_p0 == '0) || ((rem_p0 == REM_W'(1)) && (addr_p0 != MAX_ADDR)));
        if (abort) begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end else begin
          if (rem_p0 != '0) begin
            vld_nxt     = 1'b1;
            wr_addr_nxt = addr_p0;
            wr_data_nxt = cur_color_p0;
            addr_nxt    = addr_p0 + A_W'(1);
            rem_nxt     = rem_p0 - REM_W'(1);
            if (addr_p0 == MAX_ADDR) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
              rem_nxt   = '0;
              if (rem_p0 > REM_W'(1)) ovf_nxt = 1'b1;
            end
          end
          if (in_ready_c && bus.in_valid) begin
            color_nxt = tok_color;
            rem_nxt   = REM_W'(tok_run) + REM_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 (loader state) -> stage p1 (RAM write port)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_p0      <= '0;
      rem_p0       <= '0;
      cur_color_p0 <= '0;
      vld_p1       <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
      done_p1      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr_p0      <= addr_nxt;
      rem_p0       <= rem_nxt;
      cur_color_p0 <= color_nxt;
      vld_p1       <= vld_nxt;
      wr_addr_p1   <= wr_addr_nxt;
      wr_data_p1   <= wr_data_nxt;
      done_p1      <= done_nxt;
      ovf_q        <= ovf_nxt;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.wr_en    = vld_p1;
  assign bus.wr_addr  = wr_addr_p1;
  assign bus.wr_data  = wr_data_p1;
  assign busy         = (state == LOAD);
  assign done         = done_p1;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sprite_rle_loader.sv
// Directed bench for sprite_rle_loader: full fill, back-to-back runs,
// overflow, abort, random valid gaps and mid-load reset.
module tb_sprite_rle_loader;

  localparam int X_BITS  = 6;
  localparam int Y_BITS  = 6;
  localparam int COLOR_W = 12;
  localparam int RUN_W   = 4;
  localparam int NPIX    = 1 << (X_BITS + Y_BITS);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic overflow;

  always #5 clk = ~clk;

  sprite_rle_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .COLOR_W(COLOR_W), .RUN_W(RUN_W)) bus ();

  sprite_rle_loader #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .COLOR_W(COLOR_W), .RUN_W(RUN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [RUN_W-1:0]   t_run[$];
  logic [COLOR_W-1:0] t_col[$];
  logic [COLOR_W-1:0] exp_pix[NPIX];
  int exp_total, exp_ovf, exp_acc;

  int tok_i, nwr, nbad, ndone, done_addr, first_cyc, done_cyc;
  bit finished;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference RLE expansion of the token table, truncated at memory capacity
  task automatic build_ref();
    int p;
    p = 0; exp_ovf = 0; exp_acc = 0;
    for (int k = 0; k < t_run.size(); k++) begin
      if (p < NPIX) begin
        exp_acc++;
        if (p + int'(t_run[k]) + 1 > NPIX) exp_ovf = 1;
        for (int r = 0; r <= int'(t_run[k]); r++) begin
          if (p < NPIX) exp_pix[p] = t_col[k];
          p++;
        end
      end
    end
    exp_total = (p < NPIX) ? p : NPIX;
  endtask

  task automatic run_stream(input bit rnd, input int abort_at, input int budget);
    bit acc, hold, aborted;
    int drain;
    hold = 0; aborted = 0; drain = 0; finished = 0;
    tok_i = 0; nwr = 0; nbad = 0; ndone = 0;
    done_addr = -1; first_cyc = -1; done_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (tok_i < t_run.size()) begin
        bus.in_data  = {t_run[tok_i], t_col[tok_i]};
        bus.in_valid = hold || !rnd || ($urandom_range(0, 1) == 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      abort = (abort_at > 0) && (nwr == abort_at) && !aborted;
      #1;
      if (abort) begin
        aborted = 1;
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      acc  = bus.in_valid && bus.in_ready;
      hold = bus.in_valid && !bus.in_ready;
      tick();
      abort = 1'b0;
      if (acc) tok_i++;
      if (bus.wr_en) begin
        if (first_cyc < 0) first_cyc = c;
        if (nwr >= NPIX) nbad++;
        else if (bus.wr_addr !== 12'(nwr) || bus.wr_data !== exp_pix[nwr]) nbad++;
        nwr++;
      end
      if (done) begin
        ndone++;
        done_addr = int'(bus.wr_addr);
        done_cyc = c;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
      if (tok_i == t_run.size() && nwr >= exp_total) begin
        drain++;
        if (drain > 4) begin
          finished = 1;
          break;
        end
      end
    end
    chk("stream_terminated", {31'b0, finished}, 32'd1);
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en",    {31'b0, bus.wr_en}, 32'd0);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    chk("rst_done",     {31'b0, done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data",  32'(bus.wr_data), 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full fill: 256 x 16 pixels of 0xF00, valid held high
    t_run.delete(); t_col.delete();
    for (int k = 0; k < 256; k++) begin t_run.push_back(4'd15); t_col.push_back(12'hF00); end
    build_ref();
    do_start();
    run_stream(0, 0, 5000);
    chk("fill_writes",    32'(nwr), 32'd4096);
    chk("fill_bad",       32'(nbad), 32'd0);
    chk("fill_ndone",     32'(ndone), 32'd1);
    chk("fill_done_addr", 32'(done_addr), 32'd4095);
    chk("fill_gapless",   32'(done_cyc - first_cyc), 32'd4095);
    chk("fill_tokens",    32'(tok_i), 32'd256);
    chk("fill_overflow",  {31'b0, overflow}, 32'd0);
    chk("fill_busy",      {31'b0, busy}, 32'd0);
    tick();
    chk("fill_done_one_cycle", {31'b0, done}, 32'd0);

    // Overflow: 4090 pixels, then a 16-pixel run, then a token that must be refused
    t_run.delete(); t_col.delete();
    for (int k = 0; k < 255; k++) begin t_run.push_back(4'd15); t_col.push_back(12'h111); end
    t_run.push_back(4'd9);  t_col.push_back(12'h222);
    t_run.push_back(4'd15); t_col.push_back(12'h123);
    t_run.push_back(4'd0);  t_col.push_back(12'hABC);
    build_ref();
    do_start();
    run_stream(0, 0, 5000);
    chk("ovf_writes",    32'(nwr), 32'd4096);
    chk("ovf_bad",       32'(nbad), 32'd0);
    chk("ovf_last_data", 32'(bus.wr_data), 32'h123);
    chk("ovf_done_addr", 32'(done_addr), 32'd4095);
    chk("ovf_flag",      {31'b0, overflow}, 32'd1);
    chk("ovf_ref_flag",  32'(exp_ovf), 32'd1);
    chk("ovf_tokens",    32'(tok_i), 32'd257);
    bus.in_valid = 1'b1;
    bus.in_data  = {4'd0, 12'hABC};
    #1;
    chk("ovf_held_in_ready", {31'b0, bus.in_ready}, 32'd0);
    nw = 0;
    repeat (3) begin tick(); if (bus.wr_en) nw++; end
    chk("ovf_held_no_write", 32'(nw), 32'd0);
    bus.in_valid = 1'b0;

    // Abort after 100 pixels; start clears the sticky overflow
    t_run.delete(); t_col.delete();
    for (int k = 0; k < 20; k++) begin t_run.push_back(4'd9); t_col.push_back(12'h0F0); end
    build_ref();
    do_start();
    chk("start_clears_ovf", {31'b0, overflow}, 32'd0);
    run_stream(0, 100, 1000);
    chk("abort_writes", 32'(nwr), 32'd100);
    chk("abort_bad",    32'(nbad), 32'd0);
    chk("abort_ndone",  32'(ndone), 32'd0);
    chk("abort_wr_en",  {31'b0, bus.wr_en}, 32'd0);
    chk("abort_busy",   {31'b0, busy}, 32'd0);

    // Back-to-back tokens {3,0x0A0}, {0,0x00F}, restarting at address 0
    do_start();
    bus.in_valid = 1'b1;
    bus.in_data  = {4'd3, 12'h0A0};
    #1;
    chk("b2b_ready_first", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_data = {4'd0, 12'h00F};
    chk("b2b_latency", {31'b0, bus.wr_en}, 32'd0);
    #1;
    chk("b2b_ready_busy", {31'b0, bus.in_ready}, 32'd0);
    tick();
    chk("b2b_w0_en",   {31'b0, bus.wr_en}, 32'd1);
    chk("b2b_w0_addr", 32'(bus.wr_addr), 32'd0);
    chk("b2b_w0_data", 32'(bus.wr_data), 32'h0A0);
    tick();
    chk("b2b_w1_addr", 32'(bus.wr_addr), 32'd1);
    tick();
    chk("b2b_w2_addr", 32'(bus.wr_addr), 32'd2);
    #1;
    chk("b2b_ready_last_pixel", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_w3_addr", 32'(bus.wr_addr), 32'd3);
    chk("b2b_w3_data", 32'(bus.wr_data), 32'h0A0);
    tick();
    chk("b2b_w4_en",   {31'b0, bus.wr_en}, 32'd1);
    chk("b2b_w4_addr", 32'(bus.wr_addr), 32'd4);
    chk("b2b_w4_data", 32'(bus.wr_data), 32'h00F);
    tick();
    chk("b2b_idle_wr_en", {31'b0, bus.wr_en}, 32'd0);
    chk("b2b_still_busy", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b2b_abort_busy", {31'b0, busy}, 32'd0);

    // Random valid gaps with mixed run lengths
    t_run.delete(); t_col.delete();
    for (int k = 0; k < 30; k++) begin
      t_run.push_back(4'($urandom_range(0, 15)));
      t_col.push_back(12'($urandom_range(0, 4095)));
    end
    build_ref();
    do_start();
    run_stream(1, 0, 3000);
    chk("rnd_writes", 32'(nwr), 32'(exp_total));
    chk("rnd_bad",    32'(nbad), 32'd0);
    chk("rnd_ndone",  32'(ndone), 32'd0);
    chk("rnd_tokens", 32'(tok_i), 32'd30);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset in the middle of a run
    do_start();
    bus.in_valid = 1'b1;
    bus.in_data  = {4'd15, 12'h777};
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en",    {31'b0, bus.wr_en}, 32'd0);
    chk("arst_busy",     {31'b0, busy}, 32'd0);
    chk("arst_wr_addr",  32'(bus.wr_addr), 32'd0);
    chk("arst_wr_data",  32'(bus.wr_data), 32'd0);
    chk("arst_done",     {31'b0, done}, 32'd0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    nw = 0;
    repeat (10) begin tick(); if (bus.wr_en) nw++; end
    chk("arst_no_writes", 32'(nw), 32'd0);
    chk("arst_idle",      {31'b0, busy}, 32'd0);
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rle_loader.md
Name: sprite_rle_loader

Overview:
- Writer side of the sprite colour memory. The display path reads one 12-bit colour per {y,x} address.
- This block fills that memory from a run-length-encoded token stream delivered by the host/UART loader over a valid/ready handshake.
- It emits one sequential write per clock into the sprite RAM write port, in row-major order, address = {y,x}.
- Top level muxes the RAM write port to this block while busy is high.

Parameters:
- X_BITS, 6, sprite column address bits
- Y_BITS, 6, sprite row address bits; memory depth = 2^(X_BITS+Y_BITS) (4096 by default)
- COLOR_W, 12, pixel colour width (4:4:4 RGB)
- RUN_W, 4, run-length field width; a run covers run+1 pixels (1..16 by default)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a load at address 0; ignored while busy
- abort  in  1  single-cycle pulse, cancels an in-progress load
- in_valid  in  1  token valid
- in_data  in  RUN_W+COLOR_W  token {run[RUN_W-1:0], color[COLOR_W-1:0]}
- in_ready  out  1  token accepted on clk edge when in_valid && in_ready
- wr_en  out  1  memory write strobe
- wr_addr  out  X_BITS+Y_BITS  write address {y,x}
- wr_data  out  COLOR_W  write colour
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, coincident with the final write
- overflow  out  1  sticky: stream exceeded memory capacity; cleared by next start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_en, busy, done, overflow = 0.
  - wr_addr, wr_data, internal addr, rem and cur_color = 0.
- States:
  - IDLE: in_ready=0. On start: enter LOAD, addr=0, rem=0, overflow=0.
  - LOAD: busy=1.
- Internal registers: addr (next write address), rem (pixels pending, RUN_W+1 bits), cur_color.
- in_ready is combinational:
  - in_ready = (state==LOAD) && !abort && (rem==0 || (rem==1 && addr!=MAX)).
  - MAX = all-ones address.
  - This gives gapless back-to-back runs: a new token is accepted in the cycle the previous run's last pixel issues.
- Each LOAD cycle with rem!=0, registered on the edge:
  - wr_en<=1, wr_addr<=addr, wr_data<=cur_color;
  - addr<=addr+1, rem<=rem-1.
- LOAD cycle with rem==0: wr_en<=0. Waiting on in_valid is unbounded.
- Token accept on the same edge: cur_color<=color, rem<=run+1. This overrides the decrement result, which is 0 in that case.
- Latency: token accepted at edge N produces its first write visible after edge N+1 (one cycle).
- Final pixel (write issued with addr==MAX):
  - done<=1 for exactly one cycle, alongside that wr_en.
  - state<=IDLE, rem<=0.
  - If rem>1 before this write, the remaining pixels of the run are discarded and overflow<=1.
  - busy drops on the same edge.
- Tokens offered after done are never accepted (in_ready=0 in IDLE).
- Token arriving with rem==1 and addr==MAX is refused. Stalled in_valid has no effect on the RAM.
- abort in LOAD:
  - Next edge: state=IDLE, wr_en=0, rem=0, no done pulse.
  - Memory contents already written stay.
  - abort and start in the same cycle: abort wins.
- start in the same cycle as done: ignored; a new start is needed once IDLE.
- addr arithmetic is modulo 2^(X_BITS+Y_BITS), but a wrap never occurs because the load terminates at MAX.
- rst_n asserted mid-load: immediate return to reset values; no further writes.
- in_data must be stable while in_valid && !in_ready. The block samples it only on an accept.

Test Plan:
- Reset, start, then a single token {run=15, color=0xF00} repeated 256 times with in_valid held high -> 4096 consecutive wr_en cycles with no gaps, addr 0..4095, all data 0xF00; done high exactly with addr 4095; overflow=0; busy low afterward.
- Tokens {3,0x0A0}, {0,0x00F} back-to-back -> writes at addr 0..3 = 0x0A0, addr 4 = 0x00F. First write one cycle after first accept. in_ready high in the cycle addr 3 issues.
- Stream totalling 4090 pixels, then token {15,0x123} -> addrs 4090..4095 written with 0x123; done pulses; overflow=1; the next token is held with in_ready=0.
- abort after 100 pixels -> wr_en low on the next edge, no done, busy=0. A new start restarts at addr 0 and clears overflow.
- in_valid toggled randomly with a mix of run lengths -> write sequence matches a reference RLE expansion; no write issued while rem==0.
- rst_n pulled low mid-run -> all outputs 0 asynchronously; no writes after release until start.
